spi_csr_bank: RTL and testbench

//  Parametrised SPI-slave control/status register bank (SPI mode 3).

---
 rtl/spi_csr_bank.sv | 188 ++++++++++++++++++
 tb/tb_spi_csr_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_csr_bank.sv
// SPI mode-3 slave exposing NUM_REGS 8-bit control/status registers with read-back,
// read-only status slots, per-register write/read strobes and optional address auto-increment.
module spi_csr_bank #(
    parameter int unsigned           NUM_REGS     = 16,
    parameter logic [NUM_REGS*8-1:0] RESET_VALUES = '0,
    parameter logic [NUM_REGS-1:0]   RO_MASK      = '0,
    parameter logic [NUM_REGS-1:0]   WSTROBE_MASK = '0,
    parameter logic [NUM_REGS-1:0]   NOINC_MASK   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_cs,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    input  logic [NUM_REGS*8-1:0] csr_status,
    output logic [NUM_REGS*8-1:0] csr_regs,
    output logic [NUM_REGS-1:0]   csr_wstb,
    output logic [NUM_REGS-1:0]   csr_rstb,
    output logic                  csr_err
);

    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e                state_q, state_d;
    logic                  sck_q;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            rx_q, rx_d;
    logic [7:0]            tx_q, tx_d;
    logic                  miso_q, miso_d;
    logic                  rd_q, rd_d;
    logic [6:0]            addr_q, addr_d;
    logic                  pend_q, pend_d;
    logic                  pend_data_q, pend_data_d;
    logic                  fetch_q, fetch_d;
    logic                  err_q, err_d;
    logic [NUM_REGS-1:0]   wstb_q, wstb_d;
    logic [NUM_REGS-1:0]   rstb_q, rstb_d;
    logic [7:0]            regs_q [NUM_REGS];
    logic [7:0]            regs_d [NUM_REGS];

    logic                  sck_rise, sck_fall;
    logic                  addr_valid;
    logic [AW-1:0]         idx;
    logic [7:0]            rd_val;

    assign sck_rise   = spi_sck & ~sck_q;
    assign sck_fall   = ~spi_sck & sck_q;
    assign addr_valid = (32'(addr_q) < NUM_REGS);
    assign idx        = addr_q[AW-1:0];

    always_comb begin
        rd_val = 8'h00;
        if (addr_valid) begin
            if (RO_MASK[idx]) rd_val = csr_status[{idx, 3'b000} +: 8];
            else              rd_val = regs_q[idx];
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        pend_d      = 1'b0;
        pend_data_d = pend_data_q;
        fetch_d     = 1'b0;
        err_d       = err_q;
        wstb_d      = '0;
        rstb_d      = '0;
        regs_d      = regs_q;

        // A completed byte commits one clk later even if cs has since risen.
        if (pend_q) begin
            fetch_d = 1'b1;
            if (pend_data_q) begin
                if (addr_valid) begin
                    if (!rd_q && !RO_MASK[idx]) begin
                        regs_d[idx] = rx_q;
                        if (WSTROBE_MASK[idx]) wstb_d[idx] = 1'b1;
                    end
                end else begin
                    err_d = 1'b1;
                end
                if (!(addr_valid && NOINC_MASK[idx])) addr_d = addr_q + 7'd1;
            end
        end

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                tx_d      = 8'hFF;
                if (!spi_cs) begin
                    state_d = ADDR;
                    err_d   = 1'b0;
                end
            end
            default: begin
                if (spi_cs) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    tx_d      = 8'hFF;
                end else begin
                    if (fetch_q) begin
                        tx_d = rd_val;
                        if (addr_valid) begin
                            if (rd_q) rstb_d[idx] = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (sck_fall) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                    if (sck_rise) begin
                        rx_d      = {rx_q[6:0], spi_mosi};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            pend_d      = 1'b1;
                            pend_data_d = (state_q == DATA);
                            if (state_q == ADDR) begin
                                rd_d    = rx_q[6];
                                addr_d  = {rx_q[5:0], spi_mosi};
                                state_d = DATA;
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sck_q       <= 1'b1;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= 8'hFF;
            miso_q      <= 1'b1;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= 1'b0;
            fetch_q     <= 1'b0;
            err_q       <= 1'b0;
            wstb_q      <= '0;
            rstb_q      <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RO_MASK[i] ? 8'h00 : RESET_VALUES[8*i +: 8];
            end
        end else begin
            state_q     <= state_d;
            sck_q       <= spi_sck;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            fetch_q     <= fetch_d;
            err_q       <= err_d;
            wstb_q      <= wstb_d;
            rstb_q      <= rstb_d;
            regs_q      <= regs_d;
        end
    end

    always_comb begin
        csr_regs = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            csr_regs[8*i +: 8] = RO_MASK[i] ? 8'h00 : regs_q[i];
        end
    end

    assign spi_miso = miso_q;
    assign csr_wstb = wstb_q;
    assign csr_rstb = rstb_q;
    assign csr_err  = err_q;

endmodule

// File: tb/tb_spi_csr_bank.sv
// Scoreboard bench for spi_csr_bank: two configurations share the SPI bus with separate chip selects;
// expected MISO bytes and strobe pulses are queued by the stimulus and popped by monitors.
module tb_spi_csr_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, cs_a = 1'b1, cs_b = 1'b1, spi_sck = 1'b1, spi_mosi = 1'b0;
    logic miso_a, miso_b, err_a, err_b;
    logic [127:0] regs_a, regs_b;
    logic [127:0] status_a = 128'hEE00_C300_0000_0000;
    logic [127:0] status_b = '0;
    logic [15:0]  wstb_a, rstb_a, wstb_b, rstb_b;

    spi_csr_bank #(
        .NUM_REGS(16), .RESET_VALUES(128'h26), .RO_MASK(16'h0020),
        .WSTROBE_MASK(16'h0000), .NOINC_MASK(16'h0000)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .spi_cs(cs_a), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(miso_a), .csr_status(status_a), .csr_regs(regs_a),
        .csr_wstb(wstb_a), .csr_rstb(rstb_a), .csr_err(err_a)
    );

    spi_csr_bank #(
        .NUM_REGS(16), .RESET_VALUES(128'h44_3000_0000), .RO_MASK(16'h0000),
        .WSTROBE_MASK(16'h0008), .NOINC_MASK(16'h0008)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .spi_cs(cs_b), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(miso_b), .csr_status(status_b), .csr_regs(regs_b),
        .csr_wstb(wstb_b), .csr_rstb(rstb_b), .csr_err(err_b)
    );

    int n_chk = 0, n_pass = 0;
    logic [7:0]  qm_a[$], qm_b[$];
    logic [15:0] qr_a[$], qr_b[$], qw_a[$], qw_b[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic unexp(input string name, input logic [127:0] act);
        n_chk++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // MISO byte monitors (mode 3: sample on SCK rising edge, MSB first)
    initial begin
        int unsigned nb = 0;
        logic [7:0] sh = '0;
        forever begin
            @(posedge spi_sck or posedge cs_a);
            if (cs_a) nb = 0;
            else begin
                sh = {sh[6:0], miso_a};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (qm_a.size() == 0) unexp("miso_a", 128'(sh));
                    else chk("miso_a", 128'(sh), 128'(qm_a.pop_front()));
                end
            end
        end
    end

    initial begin
        int unsigned nb = 0;
        logic [7:0] sh = '0;
        forever begin
            @(posedge spi_sck or posedge cs_b);
            if (cs_b) nb = 0;
            else begin
                sh = {sh[6:0], miso_b};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (qm_b.size() == 0) unexp("miso_b", 128'(sh));
                    else chk("miso_b", 128'(sh), 128'(qm_b.pop_front()));
                end
            end
        end
    end

    // Strobe monitors: every non-zero clk of a strobe bus consumes one expected pulse
    initial forever begin
        @(negedge clk);
        if (rstb_a !== '0) begin
            if (qr_a.size() == 0) unexp("rstb_a", 128'(rstb_a));
            else chk("rstb_a", 128'(rstb_a), 128'(qr_a.pop_front()));
        end
        if (wstb_a !== '0) begin
            if (qw_a.size() == 0) unexp("wstb_a", 128'(wstb_a));
            else chk("wstb_a", 128'(wstb_a), 128'(qw_a.pop_front()));
        end
        if (rstb_b !== '0) begin
            if (qr_b.size() == 0) unexp("rstb_b", 128'(rstb_b));
            else chk("rstb_b", 128'(rstb_b), 128'(qr_b.pop_front()));
        end
        if (wstb_b !== '0) begin
            if (qw_b.size() == 0) unexp("wstb_b", 128'(wstb_b));
            else chk("wstb_b", 128'(wstb_b), 128'(qw_b.pop_front()));
        end
    end

    task automatic start(input bit sel);
        if (sel) cs_b = 1'b0;
        else     cs_a = 1'b0;
    endtask

    // Each bit: 4 clk high, fall + drive MOSI, 4 clk low, rise (task returns right after the rise).
    task automatic send_bits(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            repeat (4) @(negedge clk);
            spi_sck  = 1'b0;
            spi_mosi = d[7-i];
            repeat (4) @(negedge clk);
            spi_sck  = 1'b1;
        end
    endtask

    task automatic stop();
        @(negedge clk);
        cs_a = 1'b1;
        cs_b = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_regs_a", regs_a, 128'h26);
        chk("reset_regs_b", regs_b, 128'h44_3000_0000);
        chk("reset_miso_a", 128'(miso_a), 128'(1'b1));
        chk("reset_strobes_a", 128'({wstb_a, rstb_a}), 128'd0);
        chk("reset_err_a", 128'(err_a), 128'd0);

        // Burst write regs 2..4; data bytes shift out the old contents
        qm_a.push_back(8'hFF); qm_a.push_back(8'h00); qm_a.push_back(8'h00); qm_a.push_back(8'h00);
        start(0); send_bits(8'h02, 8);
        send_bits(8'hA5, 8); send_bits(8'h5A, 8); send_bits(8'h3C, 8);
        stop();
        chk("burst_regs", 128'(regs_a[39:16]), 128'h3C5AA5);

        // Burst read-back
        qm_a.push_back(8'hFF); qm_a.push_back(8'hA5); qm_a.push_back(8'h5A); qm_a.push_back(8'h3C);
        qr_a.push_back(16'h0004); qr_a.push_back(16'h0008); qr_a.push_back(16'h0010);
        start(0); send_bits(8'h82, 8);
        send_bits(8'h00, 8); send_bits(8'h00, 8); send_bits(8'h00, 8);
        stop();

        // Read-only slot returns status
        qm_a.push_back(8'hFF); qm_a.push_back(8'hC3);
        qr_a.push_back(16'h0020);
        start(0); send_bits(8'h85, 8); send_bits(8'h00, 8);
        stop();
        chk("ro_read_err", 128'(err_a), 128'd0);

        // Write to read-only slot is ignored without error
        qm_a.push_back(8'hFF); qm_a.push_back(8'hC3);
        start(0); send_bits(8'h05, 8); send_bits(8'h00, 8);
        stop();
        chk("ro_write_slice", 128'(regs_a[47:40]), 128'd0);
        chk("ro_write_err", 128'(err_a), 128'd0);

        // Read across the top of the map: reg15 then out-of-range addr 16
        qm_a.push_back(8'hFF); qm_a.push_back(8'h00); qm_a.push_back(8'h00);
        qr_a.push_back(16'h8000);
        start(0); send_bits(8'h8F, 8); send_bits(8'h00, 8); send_bits(8'h00, 8);
        stop();
        chk("oor_err_set", 128'(err_a), 128'd1);
        start(0);
        repeat (3) @(negedge clk);
        chk("oor_err_clear", 128'(err_a), 128'd0);
        stop();

        // Non-incrementing strobed register: three writes land on reg3
        qm_b.push_back(8'hFF); qm_b.push_back(8'h30); qm_b.push_back(8'h11); qm_b.push_back(8'h22);
        qw_b.push_back(16'h0008); qw_b.push_back(16'h0008); qw_b.push_back(16'h0008);
        start(1); send_bits(8'h03, 8);
        send_bits(8'h11, 8); send_bits(8'h22, 8); send_bits(8'h33, 8);
        stop();
        chk("noinc_reg3", 128'(regs_b[31:24]), 128'h33);
        chk("noinc_reg4", 128'(regs_b[39:32]), 128'h44);

        // Abort after 4 bits of a write data byte
        qm_b.push_back(8'hFF);
        start(1); send_bits(8'h03, 8); send_bits(8'hAA, 4);
        stop();
        chk("abort_regs_b", regs_b, 128'h44_3300_0000);

        qm_b.push_back(8'hFF); qm_b.push_back(8'h33);
        qr_b.push_back(16'h0008);
        start(1); send_bits(8'h83, 8); send_bits(8'h00, 8);
        stop();
        chk("after_abort_err", 128'(err_b), 128'd0);

        // Asynchronous reset in the middle of a read data byte
        qm_a.push_back(8'hFF);
        qr_a.push_back(16'h0004);
        start(0); send_bits(8'h82, 8); send_bits(8'h00, 4);
        @(negedge clk);
        chk("pre_reset_miso", 128'(miso_a), 128'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_miso", 128'(miso_a), 128'd1);
        chk("midrst_regs_a", regs_a, 128'h26);
        chk("midrst_err", 128'(err_a), 128'd0);
        stop();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        qm_a.push_back(8'hFF); qm_a.push_back(8'h26);
        qr_a.push_back(16'h0001);
        start(0); send_bits(8'h80, 8); send_bits(8'h00, 8);
        stop();

        chk("left_miso_a", 128'(qm_a.size()), 128'd0);
        chk("left_miso_b", 128'(qm_b.size()), 128'd0);
        chk("left_rstb_a", 128'(qr_a.size()), 128'd0);
        chk("left_rstb_b", 128'(qr_b.size()), 128'd0);
        chk("left_wstb_a", 128'(qw_a.size()), 128'd0);
        chk("left_wstb_b", 128'(qw_b.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
